// File: rtl/complex_operand_loader.sv
// Ping-pong frame assembler feeding complex_matrix_mul: collects SIZE element-pair
// beats per frame into one of two banks and presents full frames on a valid/ready bus.
module complex_operand_loader #(
    parameter int WIDTH        = 64,
    parameter int SIZE         = 16,
    parameter int NUM_OPERANDS = 4
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        flush_i,
    input  logic                                        s_valid_i,
    output logic                                        s_ready_o,
    input  logic                                        s_last_i,
    input  logic [WIDTH-1:0]                            s_a_re_i,
    input  logic [WIDTH-1:0]                            s_a_im_i,
    input  logic [WIDTH-1:0]                            s_b_re_i,
    input  logic [WIDTH-1:0]                            s_b_im_i,
    output logic [SIZE*NUM_OPERANDS-1:0][WIDTH-1:0]     operands_o,
    output logic                                        out_valid_o,
    input  logic                                        out_ready_i,
    output logic                                        frame_err_o,
    output logic                                        busy_o
);

    localparam int WORDS  = SIZE * NUM_OPERANDS;
    localparam int IDX_W  = $clog2(SIZE);
    localparam int ADDR_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

    logic [1:0][WORDS-1:0][WIDTH-1:0] bank_q;
    logic                             wr_bank_q, wr_bank_d;
    logic                             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]                 wr_idx_q, wr_idx_d;
    logic [1:0]                       full_cnt_q, full_cnt_d;
    logic                             frame_err_d;

    logic             accept;
    logic             last_slot;
    logic             complete;
    logic             early_last;
    logic             pop;
    logic [ADDR_W-1:0] word_base;

    assign accept     = s_valid_i && s_ready_o && !flush_i;
    assign last_slot  = (wr_idx_q == LAST_IDX);
    assign complete   = accept && last_slot;
    assign early_last = accept && s_last_i && !last_slot;
    assign pop        = out_valid_o && out_ready_i && !flush_i;
    assign word_base  = ADDR_W'(int'(wr_idx_q) * NUM_OPERANDS);

    assign out_valid_o = (full_cnt_q != 2'd0);
    assign operands_o  = bank_q[rd_bank_q];
    assign busy_o      = (full_cnt_q != 2'd0) || (wr_idx_q != '0);

    always_comb begin
        full_cnt_d  = full_cnt_q;
        wr_idx_d    = wr_idx_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        frame_err_d = 1'b0;
        if (flush_i) begin
            full_cnt_d = 2'd0;
            wr_idx_d   = '0;
            wr_bank_d  = 1'b0;
            rd_bank_d  = 1'b0;
        end else begin
            if (complete && !pop) begin
                full_cnt_d = full_cnt_q + 2'd1;
            end else if (pop && !complete) begin
                full_cnt_d = full_cnt_q - 2'd1;
            end
            if (accept) begin
                wr_idx_d    = (complete || early_last) ? '0 : wr_idx_q + IDX_W'(1);
                frame_err_d = last_slot ? !s_last_i : s_last_i;
            end
            if (complete) begin
                wr_bank_d = !wr_bank_q;
            end
            if (pop) begin
                rd_bank_d = !rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_cnt_q  <= 2'd0;
            wr_idx_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            s_ready_o   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            full_cnt_q  <= full_cnt_d;
            wr_idx_q    <= wr_idx_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            // Registered so that out_ready_i never reaches s_ready_o combinationally.
            s_ready_o   <= (full_cnt_d != 2'd2);
            frame_err_o <= frame_err_d;
        end
    end

    // An early-last beat is still written; the discard is just the wr_idx rewind.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bank_q <= '0;
        end else if (accept) begin
            bank_q[wr_bank_q][word_base]              <= s_a_re_i;
            bank_q[wr_bank_q][word_base + ADDR_W'(1)] <= s_a_im_i;
            bank_q[wr_bank_q][word_base + ADDR_W'(2)] <= s_b_re_i;
            bank_q[wr_bank_q][word_base + ADDR_W'(3)] <= s_b_im_i;
        end
    end

endmodule

// File: tb/tb_complex_operand_loader.sv
// Directed bench for complex_operand_loader: frame assembly, backpressure,
// same-edge pop/complete, framing errors, flush and async reset.
module tb_complex_operand_loader;

    localparam int WIDTH = 64;
    localparam int SIZE  = 16;
    localparam int NOPS  = 4;
    localparam logic [63:0] CONST_W0 = 64'h404313a0ff5f8f88;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic s_valid = 1'b0;
    logic s_ready;
    logic s_last = 1'b0;
    logic [WIDTH-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic [SIZE*NOPS-1:0][WIDTH-1:0] operands;
    logic out_valid;
    logic out_ready = 1'b0;
    logic frame_err;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    complex_operand_loader #(.WIDTH(WIDTH), .SIZE(SIZE), .NUM_OPERANDS(NOPS)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_last_i(s_last),
        .s_a_re_i(a_re), .s_a_im_i(a_im), .s_b_re_i(b_re), .s_b_im_i(b_im),
        .operands_o(operands), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .frame_err_o(frame_err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] val(input int fid, input int w);
        if (fid == 0 && w == 0) return CONST_W0;
        return {32'(fid), 32'(w + 1)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int fid, input int e, input logic last);
        s_valid = 1'b1;
        s_last  = last;
        a_re    = val(fid, e*4 + 0);
        a_im    = val(fid, e*4 + 1);
        b_re    = val(fid, e*4 + 2);
        b_im    = val(fid, e*4 + 3);
    endtask

    // Present one beat and return just after the edge that accepts it.
    task automatic send(input int fid, input int e, input logic last);
        int n;
        drive(fid, e, last);
        n = 0;
        while (!s_ready && n < 200) begin
            step();
            n++;
        end
        if (!s_ready) chk("ready_timeout", {63'd0, s_ready}, 64'd1);
        step();
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int fid, input int nbeats, input int last_at);
        for (int e = 0; e < nbeats; e++) send(fid, e, e == last_at);
    endtask

    initial begin
        int acc;
        logic took;

        // Reset state
        #2;
        chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_operands_zero", {63'd0, operands == '0}, 64'd1);
        step();
        step();
        rst = 1'b0;
        chk("rel_s_ready_before_edge", {63'd0, s_ready}, 64'd0);
        step();
        chk("rel_s_ready_after_edge", {63'd0, s_ready}, 64'd1);

        // Basic frame
        out_ready = 1'b1;
        send_frame(0, 15, -1);
        chk("basic_no_valid_early", {63'd0, out_valid}, 64'd0);
        chk("basic_busy_fill", {63'd0, busy}, 64'd1);
        send(0, 15, 1'b1);
        chk("basic_valid", {63'd0, out_valid}, 64'd1);
        chk("basic_w0", operands[0], CONST_W0);
        chk("basic_w17", operands[17], 64'd18);
        chk("basic_w63", operands[63], 64'd64);
        chk("basic_no_err", {63'd0, frame_err}, 64'd0);
        idle();
        step();
        chk("basic_valid_one_cycle", {63'd0, out_valid}, 64'd0);
        chk("basic_idle_busy", {63'd0, busy}, 64'd0);

        // Backpressure: frames 1 and 2 fill both banks
        out_ready = 1'b0;
        acc = 0;
        drive(1, 0, 1'b0);
        repeat (45) begin
            took = s_ready;
            step();
            if (took) begin
                acc++;
                drive(1 + acc/16, acc%16, (acc%16) == 15);
            end
        end
        idle();
        chk("bp_accepted", 64'(acc), 64'd32);
        chk("bp_s_ready_low", {63'd0, s_ready}, 64'd0);
        chk("bp_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_frame1_w0", operands[0], val(1, 0));
        chk("bp_frame1_w63", operands[63], val(1, 63));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_frame2_w0", operands[0], val(2, 0));
        chk("bp_frame2_w63", operands[63], val(2, 63));
        chk("bp_valid_after_pop", {63'd0, out_valid}, 64'd1);
        chk("bp_s_ready_after_pop", {63'd0, s_ready}, 64'd1);

        // Same-edge completion of frame 3 and pop of frame 2
        send_frame(3, 15, -1);
        chk("sim_hold_frame2", operands[5], val(2, 5));
        out_ready = 1'b1;
        send(3, 15, 1'b1);
        idle();
        chk("sim_valid", {63'd0, out_valid}, 64'd1);
        chk("sim_s_ready", {63'd0, s_ready}, 64'd1);
        chk("sim_frame3_w0", operands[0], val(3, 0));
        chk("sim_frame3_w63", operands[63], val(3, 63));
        step();
        chk("sim_drained", {63'd0, out_valid}, 64'd0);
        chk("sim_not_busy", {63'd0, busy}, 64'd0);

        // Early last on beat 5
        send_frame(4, 6, 5);
        idle();
        chk("early_err", {63'd0, frame_err}, 64'd1);
        chk("early_no_valid", {63'd0, out_valid}, 64'd0);
        chk("early_not_busy", {63'd0, busy}, 64'd0);
        step();
        chk("early_err_one_cycle", {63'd0, frame_err}, 64'd0);
        send_frame(5, 16, 15);
        idle();
        chk("recover_valid", {63'd0, out_valid}, 64'd1);
        chk("recover_no_err", {63'd0, frame_err}, 64'd0);
        chk("recover_w0", operands[0], val(5, 0));
        chk("recover_w20", operands[20], val(5, 20));
        step();

        // Missing last on beat 15
        send_frame(6, 16, -1);
        idle();
        chk("nolast_err", {63'd0, frame_err}, 64'd1);
        chk("nolast_valid", {63'd0, out_valid}, 64'd1);
        chk("nolast_w63", operands[63], val(6, 63));
        step();
        chk("nolast_err_clear", {63'd0, frame_err}, 64'd0);
        chk("nolast_drained", {63'd0, out_valid}, 64'd0);

        // Flush with one full frame and 7 beats held
        out_ready = 1'b0;
        send_frame(7, 16, 15);
        send_frame(8, 7, -1);
        chk("pre_flush_valid", {63'd0, out_valid}, 64'd1);
        chk("pre_flush_busy", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        drive(99, 7, 1'b1);
        step();
        flush = 1'b0;
        idle();
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_no_err", {63'd0, frame_err}, 64'd0);
        chk("flush_s_ready", {63'd0, s_ready}, 64'd1);
        send_frame(9, 16, 15);
        idle();
        chk("post_flush_valid", {63'd0, out_valid}, 64'd1);
        chk("post_flush_w0", operands[0], val(9, 0));
        chk("post_flush_w40", operands[40], val(9, 40));
        chk("post_flush_w63", operands[63], val(9, 63));

        // Async reset mid-frame
        send_frame(10, 5, -1);
        idle();
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_frame_err", {63'd0, frame_err}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_operands_zero", {63'd0, operands == '0}, 64'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_rel_s_ready_before_edge", {63'd0, s_ready}, 64'd0);
        step();
        chk("arst_rel_s_ready_after_edge", {63'd0, s_ready}, 64'd1);
        chk("arst_rel_no_valid", {63'd0, out_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
